// File: rtl/mul_share_sched.sv
// Round-robin scheduler that shares one pipelined 18x17 multiplier
// between N_REQ requesters, returning products on one tagged channel.
module mul_share_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*18-1:0]  req_a,
  input  logic [N_REQ*17-1:0]  req_b,
  output logic                 mul_ce,
  output logic [17:0]          mul_a,
  output logic [16:0]          mul_b,
  input  logic [27:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [27:0]          rsp_p,
  output logic                 busy
);

  logic              stall;
  logic              found;
  logic              xfer;
  logic [ID_W-1:0]   gnt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [17:0]       a_hold;
  logic [16:0]       b_hold;
  logic [MUL_LAT-1:0] vld;
  logic [ID_W-1:0]   ids [MUL_LAT];
  int                idx;

  assign rsp_valid = vld[MUL_LAT-1];
  assign rsp_id    = ids[MUL_LAT-1];
  assign rsp_p     = mul_p;
  assign busy      = |vld;

  // Output backpressure freezes the whole multiplier pipe.
  assign stall  = rsp_valid & ~rsp_ready;
  assign mul_ce = ~stall & reset;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
  end

  assign xfer      = found & mul_ce;
  assign req_ready = xfer ? (N_REQ'(1) << gnt) : '0;

  assign ptr_nxt = (gnt == ID_W'(N_REQ - 1))
                 ? '0 : gnt + 1'b1;

  // Operands are presented in the grant cycle, then held.
  assign mul_a = xfer ? req_a[18*int'(gnt) +: 18] : a_hold;
  assign mul_b = xfer ? req_b[17*int'(gnt) +: 17] : b_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      a_hold <= '0;
      b_hold <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_nxt;
      a_hold <= mul_a;
      b_hold <= mul_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
      for (int i = 0; i < MUL_LAT; i++) ids[i] <= '0;
    end else if (mul_ce) begin
      vld[0] <= xfer;
      ids[0] <= gnt;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld[i] <= vld[i-1];
        ids[i] <= ids[i-1];
      end
    end
  end

endmodule

// File: doc/mul_share_sched.md
# mul_share_sched

Round-robin scheduler that shares one pipelined 18-bit signed × 17-bit unsigned multiplier between `N_REQ` requesters. It sits beside the shared multiplier instance in the layer datapath. It accepts one request per cycle through per-requester valid/ready handshakes and drives the multiplier's `ce`, `din0` and `din1`. Each product returns on a single tagged response channel; response backpressure stalls the whole multiplier pipeline through `ce`.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester index width, equal to clog2(`N_REQ`).
- `MUL_LAT`, 3: multiplier latency in `ce`-enabled clock edges, from `din` capture to a valid `dout`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; at most one bit high per cycle.
- `req_a`  in  `N_REQ`*18  packed signed operands; requester i uses bits [18i+17:18i].
- `req_b`  in  `N_REQ`*17  packed unsigned operands; requester i uses bits [17i+16:17i].
- `mul_ce`  out  1  clock enable to the shared multiplier.
- `mul_a`  out  18  multiplier `din0`.
- `mul_b`  out  17  multiplier `din1`.
- `mul_p`  in  28  multiplier `dout`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  `ID_W`  index of the requester that owns `rsp_p`.
- `rsp_p`  out  28  product: low 28 bits of a × b, two's complement.
- `busy`  out  1  high when any operation is in flight or `rsp_valid` is high.

## Operation
- **Stall rule.** `stall = rsp_valid & ~rsp_ready`; `mul_ce = ~stall & reset`.
- **Arbitration.** A request is eligible when `req_valid[i]`=1. The grant goes to the first eligible index at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - `req_ready[g]=1` only when `mul_ce`=1; all `req_ready` bits are 0 during a stall or reset.
  - Arbitration is combinational from `req_valid` and `rr_ptr`.
- **Handshake.** A transfer happens when `req_valid[i] & req_ready[i]`.
  - On a transfer, `mul_a`/`mul_b` carry the granted requester's operands in the same cycle.
  - On a transfer, `rr_ptr` ← (g+1) mod `N_REQ`.
  - With no transfer, `mul_a`/`mul_b` hold their last value and `rr_ptr` holds.
- **Tracking pipe.** A `MUL_LAT`-deep shift register of {vld, id} advances only when `mul_ce`=1.
  - Stage 0 takes {transfer, g}.
  - `rsp_valid` is the last-stage vld; `rsp_id` is the last-stage id.
  - `rsp_p = mul_p` passes straight through. It is valid only while `rsp_valid`=1, and holds during a stall because the multiplier `ce` is low.
- **Requester behaviour.** A requester must hold `req_valid` and its operands stable until `req_ready`. It may drop `req_valid` without penalty.
- **Throughput.** One issue per cycle with no bubbles while `rsp_ready`=1.
- **Width.** No saturation. Overflow beyond 28 bits wraps to the low 28 bits, matching the multiplier.

## Timing
- **Reset (`reset`=0 at an edge).**
  - Clears all vld stages, `rr_ptr`←0, and all ids←0.
  - The outputs are then `rsp_valid`=0, `rsp_id`=0, `busy`=0, `mul_a`=0, `mul_b`=0.
  - `mul_ce`=0 and `req_ready`=0 combinationally while `reset`=0.
  - A reset during operation discards every in-flight product; none is reported afterwards.
- **Latency.** A transfer at edge k with no stalls gives `rsp_valid`=1 and the matching `rsp_p` in the cycle after edge k+`MUL_LAT`-1. That is a visible response `MUL_LAT` cycles after the issue cycle.
- **Stall effect.** Each stalled cycle adds exactly one cycle of latency to every in-flight operation.
- **Stall freeze.** During a stall the whole pipe freezes. No grant is issued and `rr_ptr` holds. `rsp_valid`, `rsp_id` and `rsp_p` stay stable until `rsp_ready`=1.
- **Simultaneous response and issue.** A response accepted in the same cycle as a new issue is legal. Both the accept and the issue happen in that cycle.
- **Single requester.** A single requester that is always valid is granted every cycle. `rr_ptr` wraps back to the index after it.
- **`busy`** = OR of all vld stages.

## Test plan
- **Single request latency.** Reset, then one request from requester 2 with a=-1000, b=300 → `req_ready[2]`=1 for one cycle; `MUL_LAT` cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_p`=-300000 (0xFFB6C20). `busy` drops after the accept.
- **Round-robin fairness.** All four requesters hold valid for 8 cycles with `rsp_ready`=1 → grant order 0,1,2,3,0,1,2,3 with no idle cycles; responses arrive in the same order with correct ids.
- **Backpressure.** Continuous requests, then `rsp_ready`=0 for 5 cycles → `mul_ce`=0 and every `req_ready` bit =0 for those 5 cycles; `rsp_p`/`rsp_id` stay stable. After release, no product is lost or duplicated and the grant resumes at the held `rr_ptr`.
- **Wrap-around truncation.** a=-131072, b=131071 → `rsp_p`=131072 (the low 28 bits of -17179738112).
- **Reset during operation.** Issue 3 requests, then hold `reset`=0 for 1 cycle → `rsp_valid` never asserts for the discarded operations. The next request goes to requester 0 first, because `rr_ptr`=0 after reset.
- **Sparse and skip.** Only requesters 1 and 3 are valid, with `rr_ptr`=2 → requester 3 is granted, then 1, then 3.
